// File: rtl/dmem_if.sv
// Request/response bus between the core's memory stage and dmem_responder.
// The master drives the request fields. The slave returns the response
// fields and the busy indication.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, be, input rdata, ack, err, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: a single-outstanding data-memory responder for the MIPS
// data segment. It captures one request, waits WAIT_STATES cycles, then
// performs the access on the edge that enters RESP. It answers with a
// one-cycle ack, plus err and rdata.
// Optional feature macro: DMEM_BYTE_EN. When the macro is defined, be selects
// the store lanes and a store with be=0 is an error. When it is undefined,
// every store writes the full word and be is ignored.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [3:0]    cnt;
  logic          run;
  logic          we_q, bad_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q, rdata_q;
  logic [3:0]    be_q, live_be;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic          req_bad, capture, access;
  logic          a_we, a_bad;
  logic [AW-1:0] a_idx;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;

`ifdef DMEM_BYTE_EN
  assign live_be = bus.be;
`else
  assign live_be = 4'hF;
  logic unused_be;
  assign unused_be = ^bus.be;
`endif

  // Classify the live request. The range check is done in 33 bits so that a
  // window ending exactly at 2^32 stays correct.
  always_comb begin
    off     = bus.addr - BASE_ADDR;
    req_bad = (bus.addr[1:0] != 2'b00) || (bus.addr < BASE_ADDR) ||
              ({1'b0, off} >= SPAN);
`ifdef DMEM_BYTE_EN
    if (bus.we && bus.be == 4'h0) req_bad = 1'b1;
`endif
  end

  // run drops asynchronously with reset. It keeps a request that arrives
  // during reset from being captured or from writing the RAM, because the
  // RAM block itself has no reset.
  assign capture = run && state == IDLE && bus.req;
  assign access  = (capture && WAIT_STATES == 0) ||
                   (state == WAIT && cnt == 4'd1);

  // Access operands: with zero wait states the access happens on the capture
  // edge itself, so the live inputs are used. Otherwise the captured copy is
  // used.
  always_comb begin
    a_we    = we_q;
    a_bad   = bad_q;
    a_idx   = idx_q;
    a_wdata = wdata_q;
    a_be    = be_q;
    if (state == IDLE) begin
      a_we    = bus.we;
      a_bad   = req_bad;
      a_idx   = off[AW+1:2];
      a_wdata = bus.wdata;
      a_be    = live_be;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run     <= 1'b0;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      run <= 1'b1;
      if (capture) begin
        cnt     <= WS;
        we_q    <= bus.we;
        bad_q   <= req_bad;
        idx_q   <= off[AW+1:2];
        wdata_q <= bus.wdata;
        be_q    <= live_be;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // RAM access on the edge entering RESP. Bad requests never write.
  always_ff @(posedge clk) begin
    if (access) begin
      if (a_we && !a_bad)
        for (int i = 0; i < 4; i++)
          if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      rdata_q <= mem[a_idx];
    end
  end

  // Outputs come from state alone, so reset clears them at once.
  always_comb begin
    bus.ack   = (state == RESP);
    bus.err   = (state == RESP) && bad_q;
    bus.rdata = (state == RESP && !bad_q && !we_q) ? rdata_q : 32'd0;
    bus.busy  = (state != IDLE);
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. It uses one instance with two wait
// states and one with zero wait states.
module tb_dmem_responder;
  logic clk, reset;
  int checks = 0, failures = 0;

  dmem_if b2();
  dmem_if b0();

  dmem_responder #(.WAIT_STATES(2)) u2 (.clk(clk), .reset(reset), .bus(b2));
  dmem_responder #(.WAIT_STATES(0)) u0 (.clk(clk), .reset(reset), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the two-wait-state instance. The inputs are scrambled
  // right after capture, and the task returns once the DUT is back in IDLE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat);
    b2.req = 1'b1; b2.we = we; b2.addr = addr; b2.wdata = wdata; b2.be = be;
    @(posedge clk); #1;
    b2.req = 1'b0; b2.we = ~we; b2.addr = addr + 32'd4; b2.wdata = ~wdata; b2.be = ~be;
    lat = 0;
    while (!b2.ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = b2.rdata; er = b2.err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, exp_w0;
  logic        er;
  int          lat, acks;

  initial begin
    reset = 1'b0;
    b2.req = 0; b2.we = 0; b2.addr = 0; b2.wdata = 0; b2.be = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0; b0.be = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(b2.ack), 32'd0);
    chk("rst_err", 32'(b2.err), 32'd0);
    chk("rst_rdata", b2.rdata, 32'd0);
    chk("rst_busy", 32'(b2.busy), 32'd0);
    chk("rst_busy0", 32'(b0.busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Store followed by load, with the two-cycle wait.
    txn(1'b1, 32'h10010010, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("st_lat", 32'(lat), 32'd2);
    chk("st_err", 32'(er), 32'd0);
    chk("st_rdata", rd, 32'd0);
    txn(1'b0, 32'h10010010, 32'h0, 4'h0, rd, er, lat);
    chk("ld_lat", 32'(lat), 32'd2);
    chk("ld_err", 32'(er), 32'd0);
    chk("ld_rdata", rd, 32'hDEADBEEF);

    // Byte lanes.
    txn(1'b1, 32'h10010000, 32'h11223344, 4'hF, rd, er, lat);
    txn(1'b1, 32'h10010000, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    chk("be_st_err", 32'(er), 32'd0);
`ifdef DMEM_BYTE_EN
    exp_w0 = 32'h11BB33DD;
`else
    exp_w0 = 32'hAABBCCDD;
`endif
    txn(1'b0, 32'h10010000, 32'h0, 4'hF, rd, er, lat);
    chk("be_ld", rd, exp_w0);

    // The captured address must be used even though addr changes after capture.
    txn(1'b1, 32'h10010004, 32'h0BADF00D, 4'hF, rd, er, lat);
    txn(1'b1, 32'h10010008, 32'h5A5A5A5A, 4'hF, rd, er, lat);
    txn(1'b0, 32'h10010004, 32'h0, 4'hF, rd, er, lat);
    chk("capt_addr", rd, 32'h0BADF00D);

    // Error cases, plus the last valid word.
    txn(1'b1, 32'h10010FFC, 32'h0000FFFC, 4'hF, rd, er, lat);
    chk("last_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10010002, 32'h0, 4'hF, rd, er, lat);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_lat", 32'(lat), 32'd2);
    txn(1'b1, 32'h1000FFFC, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("low_err", 32'(er), 32'd1);
    chk("low_rdata", rd, 32'd0);
    txn(1'b1, 32'h10011000, 32'hEEEEEEEE, 4'hF, rd, er, lat);
    chk("high_err", 32'(er), 32'd1);
    chk("high_rdata", rd, 32'd0);
`ifdef DMEM_BYTE_EN
    txn(1'b1, 32'h10010000, 32'h99999999, 4'h0, rd, er, lat);
    chk("be0_err", 32'(er), 32'd1);
`endif
    txn(1'b0, 32'h10010FFC, 32'h0, 4'hF, rd, er, lat);
    chk("last_keep", rd, 32'h0000FFFC);
    txn(1'b0, 32'h10010000, 32'h0, 4'hF, rd, er, lat);
    chk("w0_keep", rd, exp_w0);

    // Reset during WAIT abandons the store.
    txn(1'b1, 32'h10010020, 32'hCAFEBABE, 4'hF, rd, er, lat);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h10010020; b2.wdata = 32'h12345678; b2.be = 4'hF;
    @(posedge clk); #1;
    b2.req = 1'b0;
    chk("mid_busy", 32'(b2.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_ack", 32'(b2.ack), 32'd0);
    chk("mid_err", 32'(b2.err), 32'd0);
    chk("mid_rdata", b2.rdata, 32'd0);
    chk("mid_busy0", 32'(b2.busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h10010020, 32'h0, 4'hF, rd, er, lat);
    chk("mid_keep", rd, 32'hCAFEBABE);

    // Zero wait states: store and load, each with the ack in the first cycle.
    b0.req = 1'b1; b0.we = 1'b1; b0.addr = 32'h10010040; b0.wdata = 32'h600DCAFE; b0.be = 4'hF;
    @(posedge clk); #1;
    b0.req = 1'b0;
    chk("z_st_ack", 32'(b0.ack), 32'd1);
    @(posedge clk); #1;
    b0.req = 1'b1; b0.we = 1'b0;
    @(posedge clk); #1;
    chk("z_ld_ack", 32'(b0.ack), 32'd1);
    chk("z_ld_rdata", b0.rdata, 32'h600DCAFE);
    b0.req = 1'b0;
    @(posedge clk); #1;

    // Zero-wait-state throughput with req held high: one transaction every two cycles.
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 32'h10010040;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("thr_ack%0d", i), 32'(b0.ack), 32'((i % 2) == 0));
      chk($sformatf("thr_busy%0d", i), 32'(b0.busy), 32'((i % 2) == 0));
      if (b0.ack) acks++;
      if (i == 4) b0.req = 1'b0;
    end
    chk("thr_count", 32'(acks), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
